// File: rtl/herm_inserter.sv
// Hermitian symmetry inserter: buffers one burst of active subcarriers and streams
// 64-bin IFFT frames with zeroed DC/guard bins and conjugate-mirrored upper bins.
// Optional macro HERM_SATURATE_EN: conjugate negation saturates -128 to +127.
module herm_inserter #(
    parameter int ACTIVE_SUBCARR = 28,
    parameter int SYMBOL_NUM     = 8,
    parameter int CEST_NUM       = 4,
    parameter int FFT_POINT      = 64,
    parameter int DATA_W         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              wren,
    input  logic              tx_done,
    output logic              in_buff_full,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_sof,
    output logic              frame_done
);

    localparam int SYMS      = SYMBOL_NUM + CEST_NUM;
    localparam int DEPTH     = ACTIVE_SUBCARR * SYMS;
    localparam int AW        = $clog2(DEPTH);
    localparam int BIN_W     = $clog2(FFT_POINT);
    localparam int SYM_W     = $clog2(SYMS);
    localparam int HALF_W    = DATA_W / 2;
    localparam int MIRROR_LO = FFT_POINT - ACTIVE_SUBCARR;

    typedef enum logic [1:0] {LOAD, EMIT, DONE} state_t;

    state_t             state;
    logic [AW-1:0]      wr_cnt;
    logic [SYM_W-1:0]   sym;
    logic [BIN_W-1:0]   bin;
    logic               fetch_on;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DATA_W-1:0]  rd_data_p1;
    logic               vld_p1, zero_p1, conj_p1, sof_p1, last_p1;
    logic               last_p2;

    logic               adv, rd_en, mem_we;
    logic               bin_lo, bin_mir, bin_zero, bin_last;
    logic [AW-1:0]      rd_addr;
    int                 off;

    function automatic logic signed [HALF_W-1:0] neg_im(input logic signed [HALF_W-1:0] v);
`ifdef HERM_SATURATE_EN
        if (v == {1'b1, {(HALF_W-1){1'b0}}})
            return {1'b0, {(HALF_W-1){1'b1}}};
`endif
        return -v;
    endfunction

    function automatic logic [DATA_W-1:0] conj(input logic [DATA_W-1:0] v);
        logic signed [HALF_W-1:0] im;
        im = v[HALF_W-1:0];
        return {v[DATA_W-1:HALF_W], neg_im(im)};
    endfunction

    // The whole read pipeline freezes together while the IFFT holds off a valid beat.
    assign adv    = !dout_valid || dout_ready;
    assign rd_en  = (state == EMIT) && adv && fetch_on;
    assign mem_we = (state == LOAD) && wren && !tx_done;

    always_comb begin
        bin_lo   = (int'(bin) >= 1) && (int'(bin) <= ACTIVE_SUBCARR);
        bin_mir  = (int'(bin) >= MIRROR_LO);
        bin_zero = !bin_lo && !bin_mir;
        bin_last = (int'(sym) == SYMS - 1) && (int'(bin) == FFT_POINT - 1);
        off      = 0;
        if (bin_lo)
            off = int'(bin) - 1;
        else if (bin_mir)
            off = FFT_POINT - 1 - int'(bin);
        rd_addr  = AW'(int'(sym) * ACTIVE_SUBCARR + off);
    end

    // Stage p1: synchronous buffer write and read
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wr_cnt] <= din;
        if (rd_en)
            rd_data_p1 <= mem[rd_addr];
    end

    // Stage p2: bin value to the registered output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dout <= '0;
        else if ((state == EMIT) && adv)
            dout <= zero_p1 ? '0 : (conj_p1 ? conj(rd_data_p1) : rd_data_p1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LOAD;
            wr_cnt       <= '0;
            in_buff_full <= 1'b0;
            frame_done   <= 1'b0;
            sym          <= '0;
            bin          <= '0;
            fetch_on     <= 1'b0;
            vld_p1       <= 1'b0;
            zero_p1      <= 1'b0;
            conj_p1      <= 1'b0;
            sof_p1       <= 1'b0;
            last_p1      <= 1'b0;
            dout_valid   <= 1'b0;
            dout_sof     <= 1'b0;
            last_p2      <= 1'b0;
        end else if (tx_done) begin
            state        <= LOAD;
            wr_cnt       <= '0;
            in_buff_full <= 1'b0;
            frame_done   <= 1'b0;
            sym          <= '0;
            bin          <= '0;
            fetch_on     <= 1'b0;
            vld_p1       <= 1'b0;
            dout_valid   <= 1'b0;
            dout_sof     <= 1'b0;
            last_p2      <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (wren) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt == AW'(DEPTH - 1)) begin
                            in_buff_full <= 1'b1;
                            state        <= EMIT;
                            fetch_on     <= 1'b1;
                            sym          <= '0;
                            bin          <= '0;
                        end
                    end
                end
                EMIT: begin
                    if (adv) begin
                        vld_p1     <= fetch_on;
                        zero_p1    <= bin_zero;
                        conj_p1    <= bin_mir;
                        sof_p1     <= (bin == '0);
                        last_p1    <= bin_last;
                        dout_valid <= vld_p1;
                        dout_sof   <= vld_p1 && sof_p1;
                        last_p2    <= vld_p1 && last_p1;
                        if (fetch_on) begin
                            if (int'(bin) == FFT_POINT - 1) begin
                                bin <= '0;
                                if (bin_last)
                                    fetch_on <= 1'b0;
                                else
                                    sym <= sym + 1'b1;
                            end else begin
                                bin <= bin + 1'b1;
                            end
                        end
                    end
                    if (dout_valid && dout_ready && last_p2) begin
                        frame_done <= 1'b1;
                        state      <= DONE;
                        dout_valid <= 1'b0;
                        dout_sof   <= 1'b0;
                        vld_p1     <= 1'b0;
                        last_p2    <= 1'b0;
                    end
                end
                default: begin
                    dout_valid <= 1'b0;
                    dout_sof   <= 1'b0;
                end
            endcase
        end
    end

endmodule
